// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared types and constants for the multiplexed 7-segment
//               display driver: scan state enum, segment bit positions and
//               the hex-to-segment table (active-high, seg a = bit 0).
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } disp_state_e;

    localparam int c_SEG_A = 0;
    localparam int c_SEG_B = 1;
    localparam int c_SEG_C = 2;
    localparam int c_SEG_D = 3;
    localparam int c_SEG_E = 4;
    localparam int c_SEG_F = 5;
    localparam int c_SEG_G = 6;
    localparam int c_SEG_W = c_SEG_G + 1;

    // Glyphs 0-9, A, b, C, d, E, F
    localparam logic [c_SEG_W-1:0] c_HEX_SEG [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [c_SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
        return c_HEX_SEG[nib];
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan_timer
// Description : Scan sequencer. Alternates BLANK (BLANK_CYCLES) and SHOW
//               (DWELL_CYCLES) per digit, advancing the digit index after
//               each SHOW and wrapping at NUM_DIGITS-1.
// Ports       : clk, rst_n      - clock, async active-low reset
//               state          - current scan state (BLANK/SHOW)
//               index          - digit currently being scanned
//               boundary       - high in the last SHOW cycle of the last
//                                digit; the following edge starts a frame
// Revision    : 1.0 - initial release
// ============================================================================
module disp_scan_timer
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 10000,
    parameter int BLANK_CYCLES = 100,
    parameter int CNT_W        = 14,
    parameter int IDX_W        = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output disp_state_e       state,
    output logic [IDX_W-1:0]  index,
    output logic              boundary
);

    localparam logic [CNT_W-1:0] c_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    disp_state_e        r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_cnt == c_BLANK_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_SHOW;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == c_DWELL_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_BLANK;
                        r_idx   <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_BLANK;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign state    = r_state;
    assign index    = r_idx;
    assign boundary = (r_state == ST_SHOW) && (r_cnt == c_DWELL_LAST) &&
                      (r_idx == c_IDX_LAST);

endmodule
`default_nettype wire

// File: rtl/disp_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan_mux
// Description : Time-multiplexed multi-digit 7-segment driver. New values
//               are captured into staging on load and copied into the
//               displayed (shadow) set only at frame boundaries, so a frame
//               never mixes old and new digits.
// Ports       : clk, rst_n  - clock, async active-low reset
//               load        - capture digits_in/dp_in/mask_in into staging
//               digits_in   - nibble i at [4i+3:4i], digit 0 scanned first
//               dp_in       - decimal point per digit
//               mask_in     - 1 = digit enabled, 0 = kept dark
//               seg_out     - segments a..g (bit 0 = a)
//               dp_out      - decimal point of the lit digit
//               dig_sel     - one-hot digit select, none during blank
//               frame_done  - one-cycle pulse at the start of each frame
//               All display outputs are inverted when ACTIVE_LOW != 0.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 10000,
    parameter int BLANK_CYCLES = 100,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   mask_in,
    output logic [c_SEG_W-1:0]      seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int   c_CNT_MAX = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
    localparam int   c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int   c_IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic c_INV     = (ACTIVE_LOW != 0);

    disp_state_e           w_state;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_boundary;

    disp_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (c_CNT_W),
        .IDX_W        (c_IDX_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .state    (w_state),
        .index    (w_idx),
        .boundary (w_boundary)
    );

    // ---------------- staging / shadow ----------------
    logic [4*NUM_DIGITS-1:0] r_stg_digits, r_sh_digits;
    logic [NUM_DIGITS-1:0]   r_stg_dp,     r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_stg_mask,   r_sh_mask;
    logic                    r_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_digits <= '0;
            r_stg_dp     <= '0;
            r_stg_mask   <= '0;
            r_sh_digits  <= '0;
            r_sh_dp      <= '0;
            r_sh_mask    <= '0;
            r_pending    <= 1'b0;
        end else begin
            // Shadow takes the pre-edge staging; a load on the boundary edge
            // therefore stays pending for the following frame.
            if (w_boundary && r_pending) begin
                r_sh_digits <= r_stg_digits;
                r_sh_dp     <= r_stg_dp;
                r_sh_mask   <= r_stg_mask;
            end
            if (load) begin
                r_stg_digits <= digits_in;
                r_stg_dp     <= dp_in;
                r_stg_mask   <= mask_in;
                r_pending    <= 1'b1;
            end else if (w_boundary) begin
                r_pending    <= 1'b0;
            end
        end
    end

    // ---------------- decode and masking ----------------
    logic                    w_lit;
    logic [3:0]              w_nib;
    logic [c_SEG_W-1:0]      w_seg;
    logic                    w_dp;
    logic [NUM_DIGITS-1:0]   w_sel;

    always_comb begin
        w_nib = r_sh_digits[{w_idx, 2'b00} +: 4];
        w_lit = (w_state == ST_SHOW) && r_sh_mask[w_idx];
        w_seg = '0;
        w_dp  = 1'b0;
        w_sel = '0;
        if (w_lit) begin
            w_seg        = hex_to_seg(w_nib);
            w_dp         = r_sh_dp[w_idx];
            w_sel[w_idx] = 1'b1;
        end
    end

    // ---------------- registered outputs ----------------
    // Outputs lag the scan state by one cycle; frame_done is delayed the same
    // way so it lines up with the first blank cycle seen on the pins.
    logic [c_SEG_W-1:0]      r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_sel;
    logic                    r_bnd_q;
    logic                    r_frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= {c_SEG_W{c_INV}};
            r_dp         <= c_INV;
            r_sel        <= {NUM_DIGITS{c_INV}};
            r_bnd_q      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg ^ {c_SEG_W{c_INV}};
            r_dp         <= w_dp ^ c_INV;
            r_sel        <= w_sel ^ {NUM_DIGITS{c_INV}};
            r_bnd_q      <= w_boundary;
            r_frame_done <= r_bnd_q;
        end
    end

    assign seg_out    = r_seg;
    assign dp_out     = r_dp;
    assign dig_sel    = r_sel;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
